display_scan: RTL and testbench

// - Parametrised multiplexed seven-segment scanner; successor to the fixed 4-digit display driver.
// - Time-multiplexes NUM_DIGITS digits onto shared anode/cathode pins:
//   - per-digit blanking
//   - PWM brightness
//   - tear-free shadow-register updates committed on frame boundaries.
// - Sits between the PicoBlaze output-port registers and the board's display pins.

---
 rtl/display_scan.sv | 165 ++++++++++++++++
 tb/tb_display_scan.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/display_scan.sv
// display_scan
//   Multiplexed seven-segment scanner. NUM_DIGITS digits share the anode and
//   cathode pins; each digit owns one prescaler slot of 2**PRESCALE_W clocks.
//   New segment/blank data is captured into a pending shadow on 'load' and
//   only becomes visible at a frame boundary, so a frame is never torn.
//   Brightness is a live PWM duty select within each slot.
//
//   Optional build macro: DISPLAY_SCAN_HEX_DECODE_EN
//     defined     -> each byte's low nibble is a hex digit decoded to a 0-F
//                    glyph; bit 7 is the decimal point, bits [6:4] ignored.
//     not defined -> bytes are raw segment patterns, no decoder is built.
//
// Ports
//   clk        in   system clock
//   reset      in   asynchronous, active-high reset
//   load       in   1-cycle strobe capturing segments/blank into the pending shadow
//   segments   in   byte i = digit i, {dp,g,f,e,d,c,b,a}, 1 = lit
//   blank      in   bit i = 1 keeps digit i dark (captured with load)
//   brightness in   live duty select, all-ones = always on
//   anode      out  digit select, polarity set by ANODE_ACTIVE_LOW
//   cathode    out  segment drive, polarity set by CATHODE_ACTIVE_LOW
//   frame_done out  1-cycle pulse after the last digit slot of a frame
module display_scan #(
  parameter int NUM_DIGITS         = 4,
  parameter int PRESCALE_W         = 16,
  parameter int BRIGHT_W           = 3,
  parameter int ANODE_ACTIVE_LOW   = 1,
  parameter int CATHODE_ACTIVE_LOW = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic [NUM_DIGITS*8-1:0] segments,
  input  logic [NUM_DIGITS-1:0]   blank,
  input  logic [BRIGHT_W-1:0]     brightness,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic [7:0]              cathode,
  output logic                    frame_done
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IDX_W-1:0]      LAST_IDX  = IDX_W'(NUM_DIGITS - 1);
  // Pin levels for "off"; XOR with these converts logical to pin polarity.
  localparam logic [NUM_DIGITS-1:0] ANODE_OFF = {NUM_DIGITS{ANODE_ACTIVE_LOW != 0}};
  localparam logic [7:0]            CATH_OFF  = {8{CATHODE_ACTIVE_LOW != 0}};

  logic [PRESCALE_W-1:0]   presc_q, presc_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [NUM_DIGITS*8-1:0] pend_seg_q, pend_seg_d;
  logic [NUM_DIGITS-1:0]   pend_blank_q, pend_blank_d;
  logic                    pend_valid_q, pend_valid_d;
  logic [NUM_DIGITS*8-1:0] act_seg_q, act_seg_d;
  logic [NUM_DIGITS-1:0]   act_blank_q, act_blank_d;
  logic [NUM_DIGITS-1:0]   anode_q, anode_d;
  logic [7:0]              cathode_q, cathode_d;
  logic                    frame_done_q, frame_done_d;

  logic                    slot_end;
  logic                    boundary;
  logic                    pwm_on;
  logic                    lit;
  logic [7:0]              glyph;
  logic [NUM_DIGITS-1:0]   anode_log;

  // One-hot logical anode: only the scanned digit can be selected.
  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_anode
      assign anode_log[gi] = lit && (idx_q == IDX_W'(gi));
    end
  endgenerate

  always_comb begin
    slot_end     = &presc_q;
    boundary     = slot_end && (idx_q == LAST_IDX);

    presc_d      = presc_q + PRESCALE_W'(1);
    idx_d        = idx_q;
    if (slot_end) begin
      idx_d = boundary ? '0 : idx_q + IDX_W'(1);
    end

    pend_seg_d   = pend_seg_q;
    pend_blank_d = pend_blank_q;
    pend_valid_d = pend_valid_q;
    act_seg_d    = act_seg_q;
    act_blank_d  = act_blank_q;

    // Commit uses the pending value held before this cycle; a load in the
    // same cycle therefore stays pending until the following boundary.
    if (boundary && pend_valid_q) begin
      act_seg_d    = pend_seg_q;
      act_blank_d  = pend_blank_q;
      pend_valid_d = 1'b0;
    end
    if (load) begin
      pend_seg_d   = segments;
      pend_blank_d = blank;
      pend_valid_d = 1'b1;
    end

    // PWM compares the top bits of the slot counter against the duty value.
    pwm_on = (&brightness) ||
             (presc_q[PRESCALE_W-1 -: BRIGHT_W] < brightness);
    lit    = pwm_on && !act_blank_q[idx_q];

`ifdef DISPLAY_SCAN_HEX_DECODE_EN
    glyph[7] = act_seg_q[{idx_q, 3'b111}];
    case (act_seg_q[{idx_q, 3'b000} +: 4])
      4'h0: glyph[6:0] = 7'h3F;
      4'h1: glyph[6:0] = 7'h06;
      4'h2: glyph[6:0] = 7'h5B;
      4'h3: glyph[6:0] = 7'h4F;
      4'h4: glyph[6:0] = 7'h66;
      4'h5: glyph[6:0] = 7'h6D;
      4'h6: glyph[6:0] = 7'h7D;
      4'h7: glyph[6:0] = 7'h07;
      4'h8: glyph[6:0] = 7'h7F;
      4'h9: glyph[6:0] = 7'h6F;
      4'hA: glyph[6:0] = 7'h77;
      4'hB: glyph[6:0] = 7'h7C;
      4'hC: glyph[6:0] = 7'h39;
      4'hD: glyph[6:0] = 7'h5E;
      4'hE: glyph[6:0] = 7'h79;
      default: glyph[6:0] = 7'h71;
    endcase
`else
    glyph = act_seg_q[{idx_q, 3'b000} +: 8];
`endif

    anode_d      = anode_log ^ ANODE_OFF;
    cathode_d    = (lit ? glyph : 8'h00) ^ CATH_OFF;
    frame_done_d = boundary;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q      <= '0;
      idx_q        <= '0;
      pend_seg_q   <= '0;
      pend_blank_q <= '0;
      pend_valid_q <= 1'b0;
      act_seg_q    <= '0;
      act_blank_q  <= '1;
      anode_q      <= ANODE_OFF;
      cathode_q    <= CATH_OFF;
      frame_done_q <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      pend_seg_q   <= pend_seg_d;
      pend_blank_q <= pend_blank_d;
      pend_valid_q <= pend_valid_d;
      act_seg_q    <= act_seg_d;
      act_blank_q  <= act_blank_d;
      anode_q      <= anode_d;
      cathode_q    <= cathode_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign anode      = anode_q;
  assign cathode    = cathode_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_display_scan.sv
// Testbench for display_scan (NUM_DIGITS=4, PRESCALE_W=4, BRIGHT_W=2,
// active-low anode and cathode). Each expected digit slot is queued when its
// stimulus is set up; the monitor summarises every observed slot and pops
// one expectation per slot.
module tb_display_scan;

  localparam int ND = 4;
  localparam int PW = 4;
  localparam int BW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          load = 1'b0;
  logic [31:0]   segments = '0;
  logic [3:0]    blank = '0;
  logic [1:0]    brightness = 2'd3;
  logic [3:0]    anode;
  logic [7:0]    cathode;
  logic          frame_done;

  always #5 clk = ~clk;

  display_scan #(
    .NUM_DIGITS(ND), .PRESCALE_W(PW), .BRIGHT_W(BW),
    .ANODE_ACTIVE_LOW(1), .CATHODE_ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .reset(rst), .load(load), .segments(segments),
    .blank(blank), .brightness(brightness), .anode(anode),
    .cathode(cathode), .frame_done(frame_done)
  );

  typedef struct packed {
    logic [3:0] an;
    logic [7:0] cath;
    logic [4:0] lit;
    logic [1:0] fd;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;       // clock edges since reset release
  int   first_fd = 0;  // 1-based cycle in which frame_done was first seen

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Pin-level cathode expected for a byte (active-low).
  function automatic logic [7:0] exp_cath(input logic [7:0] b);
    logic [7:0] lg;
`ifdef DISPLAY_SCAN_HEX_DECODE_EN
    case (b[3:0])
      4'h0: lg = 8'h3F; 4'h1: lg = 8'h06; 4'h2: lg = 8'h5B; 4'h3: lg = 8'h4F;
      4'h4: lg = 8'h66; 4'h5: lg = 8'h6D; 4'h6: lg = 8'h7D; 4'h7: lg = 8'h07;
      4'h8: lg = 8'h7F; 4'h9: lg = 8'h6F; 4'hA: lg = 8'h77; 4'hB: lg = 8'h7C;
      4'hC: lg = 8'h39; 4'hD: lg = 8'h5E; 4'hE: lg = 8'h79; default: lg = 8'h71;
    endcase
    lg[7] = b[7];
`else
    lg = b;
`endif
    return ~lg;
  endfunction

  // Queue the four slot expectations of one output frame.
  task automatic push_frame(input logic [31:0] pat, input logic [3:0] blk, input logic [1:0] br);
    for (int d = 0; d < ND; d++) begin
      exp_t e;
      int   l;
      l      = blk[d] ? 0 : ((br == 2'd3) ? 16 : 4 * int'(br));
      e.lit  = 5'(l);
      e.an   = (l != 0) ? ~(4'b0001 << d) : 4'hF;
      e.cath = (l != 0) ? exp_cath(pat[8*d +: 8]) : 8'hFF;
      e.fd   = (d == ND - 1) ? 2'd1 : 2'd0;
      sb_q.push_back(e);
    end
  endtask

  // Advance to 2 time units after edge number n (inputs set here are
  // sampled at edge n+1).
  task automatic goto(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic do_load(input int at, input logic [31:0] p, input logic [3:0] b);
    goto(at);
    segments = p;
    blank    = b;
    load     = 1'b1;
    goto(at + 1);
    load     = 1'b0;
  endtask

  // Monitor: one summary per 16-cycle output slot.
  initial begin : monitor
    int         lit_cnt;
    int         fd_cnt;
    logic [3:0] an_seen;
    logic [7:0] cath_seen;
    logic [7:0] dark_cath;
    exp_t       e;
    lit_cnt = 0; fd_cnt = 0; an_seen = 4'hF; cath_seen = 8'hFF; dark_cath = 8'hFF;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        cyc = 0;
        lit_cnt = 0; fd_cnt = 0; an_seen = 4'hF; cath_seen = 8'hFF; dark_cath = 8'hFF;
      end else begin
        cyc++;
        if (anode != 4'hF) begin
          lit_cnt++;
          an_seen   = anode;
          cath_seen = cathode;
        end else if (cathode != 8'hFF) begin
          dark_cath = cathode;
        end
        if (frame_done) begin
          fd_cnt++;
          if (first_fd == 0) first_fd = cyc + 1;
        end
        if (cyc % 16 == 0) begin
          check_val($sformatf("slot%0d_sb_avail", cyc / 16 - 1), 32'(sb_q.size() > 0), 1);
          if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_val($sformatf("slot%0d_anode", cyc / 16 - 1), 32'(an_seen), 32'(e.an));
            check_val($sformatf("slot%0d_cathode", cyc / 16 - 1), 32'(cath_seen), 32'(e.cath));
            check_val($sformatf("slot%0d_lit_cycles", cyc / 16 - 1), 32'(lit_cnt), 32'(e.lit));
            check_val($sformatf("slot%0d_frame_done", cyc / 16 - 1), 32'(fd_cnt), 32'(e.fd));
            check_val($sformatf("slot%0d_dark_cathode", cyc / 16 - 1), 32'(dark_cath), 32'hFF);
          end
          lit_cnt = 0; fd_cnt = 0; an_seen = 4'hF; cath_seen = 8'hFF; dark_cath = 8'hFF;
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    // Asynchronous reset takes effect without a clock edge.
    #1 rst = 1'b1;
    #1;
    check_val("rst_async_anode", 32'(anode), 32'hF);
    check_val("rst_async_cathode", 32'(cathode), 32'hFF);
    check_val("rst_async_frame_done", 32'(frame_done), 0);
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_hold_anode", 32'(anode), 32'hF);
    check_val("rst_hold_cathode", 32'(cathode), 32'hFF);
    @(negedge clk);
    rst = 1'b0;

    // Frame 0: nothing committed yet, dark; mid-frame load shows next frame.
    push_frame(32'h0, 4'hF, 2'd3);
    do_load(20, 32'h3F06_5B4F, 4'h0);
    // Frame 1: full brightness.
    goto(64);
    push_frame(32'h3F06_5B4F, 4'h0, 2'd3);
    // Frame 2: quarter duty.
    goto(128);
    brightness = 2'd1;
    push_frame(32'h3F06_5B4F, 4'h0, 2'd1);
    check_val("first_frame_done_cycle", 32'(first_fd), 65);
    // Frame 3: brightness 0 keeps all dark; queue a blanked pattern.
    goto(192);
    brightness = 2'd0;
    push_frame(32'h3F06_5B4F, 4'h0, 2'd0);
    do_load(222, 32'h1234_5678, 4'b0100);
    // Frame 4: digit 2 blanked; mid-frame load, then a load on the boundary.
    goto(256);
    brightness = 2'd3;
    push_frame(32'h1234_5678, 4'b0100, 2'd3);
    do_load(266, 32'h0FF0_55AA, 4'h0);
    do_load(319, 32'h8001_7FC3, 4'h0);
    // Frame 5: prior pending committed at that boundary.
    push_frame(32'h0FF0_55AA, 4'h0, 2'd3);
    // Frame 6: boundary-load data one frame later; two loads, last wins.
    goto(384);
    push_frame(32'h8001_7FC3, 4'h0, 2'd3);
    do_load(400, 32'h1122_3344, 4'h0);
    do_load(420, 32'h088A_6D06, 4'h0);
    // Frame 7 and 8.
    goto(448);
    push_frame(32'h088A_6D06, 4'h0, 2'd3);
    goto(512);
    push_frame(32'h088A_6D06, 4'h0, 2'd3);

    // Mid-frame reset: immediately dark, active stays blank afterwards.
    goto(537);
    check_val("pre_rst_lit", 32'(anode != 4'hF), 1);
    rst = 1'b1;
    #1;
    check_val("midrst_anode", 32'(anode), 32'hF);
    check_val("midrst_cathode", 32'(cathode), 32'hFF);
    check_val("midrst_frame_done", 32'(frame_done), 0);
    sb_q.delete();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    push_frame(32'h0, 4'hF, 2'd3);
    goto(64);
    check_val("sb_drained", 32'(sb_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
